// File: rtl/dsram_responder_pkg.sv
// Shared address map for dsram_responder: default window bases, MMIO register
// offsets and the TXSTAT bit layout.
package dsram_responder_pkg;

  localparam logic [31:0] DEF_RAM_BASE  = 32'h1C00_0000;
  localparam int          DEF_RAM_AW    = 8;
  localparam logic [31:0] DEF_MMIO_BASE = 32'hBFAF_0000;

  localparam logic [15:0] OFF_LED    = 16'hF000;
  localparam logic [15:0] OFF_SWITCH = 16'hF004;
  localparam logic [15:0] OFF_TIMER  = 16'hF008;
  localparam logic [15:0] OFF_TXDATA = 16'hF010;
  localparam logic [15:0] OFF_TXSTAT = 16'hF014;

  localparam int TXSTAT_EMPTY   = 0;
  localparam int TXSTAT_FULL    = 1;
  localparam int TXSTAT_OVF     = 2;
  localparam int TXSTAT_CNT_LSB = 4;

  localparam logic [2:0] FIFO_DEPTH = 3'd4;

  function automatic logic [31:0] txstat_pack(
    input logic [2:0] count,
    input logic       ovf,
    input logic       full,
    input logic       empty
  );
    logic [31:0] v;
    v = 32'h0000_0000;
    v[TXSTAT_CNT_LSB +: 3] = count;
    v[TXSTAT_OVF]          = ovf;
    v[TXSTAT_FULL]         = full;
    v[TXSTAT_EMPTY]        = empty;
    return v;
  endfunction

endpackage

// File: rtl/dsram_responder_tx_fifo4.sv
// Four-entry byte FIFO feeding the TX port; pushes while full and pops while
// empty are silently refused, full/empty are taken from the pre-edge count.
module tx_fifo4
  import dsram_responder_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic       o_full,
  output logic       o_empty,
  output logic [2:0] o_count,
  output logic [7:0] o_head
);

  logic [7:0] r_mem [0:3];
  logic [1:0] r_wptr;
  logic [1:0] r_rptr;
  logic [2:0] r_count;
  logic       w_push_acc;
  logic       w_pop_acc;

  assign o_full     = (r_count == FIFO_DEPTH);
  assign o_empty    = (r_count == 3'd0);
  assign o_count    = r_count;
  assign o_head     = o_empty ? 8'h00 : r_mem[r_rptr];
  assign w_push_acc = i_push && !o_full;
  assign w_pop_acc  = i_pop && !o_empty;

  // Storage array: data only, never cleared.
  always_ff @(posedge clk) begin
    if (!reset && w_push_acc) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= 2'd0;
      r_rptr  <= 2'd0;
      r_count <= 3'd0;
    end else begin
      if (w_push_acc) begin
        r_wptr <= r_wptr + 2'd1;
      end
      if (w_pop_acc) begin
        r_rptr <= r_rptr + 2'd1;
      end
      case ({w_push_acc, w_pop_acc})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dsram_responder.sv
// CPU data-port responder: zero-latency word RAM plus an MMIO block with LEDs,
// synchronised switches, a free-running timer and a small TX byte FIFO.
module dsram_responder
  import dsram_responder_pkg::*;
#(
  parameter logic [31:0] RAM_BASE  = DEF_RAM_BASE,
  parameter int          RAM_AW    = DEF_RAM_AW,
  parameter logic [31:0] MMIO_BASE = DEF_MMIO_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch,
  output logic [15:0] led,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  logic [31:0]       r_mem [0:(1<<RAM_AW)-1];
  logic [15:0]       r_led;
  logic [7:0]        r_sw_meta;
  logic [7:0]        r_sw_sync;
  logic [31:0]       r_timer;
  logic              r_ovf;

  logic              w_ram_hit;
  logic              w_mmio_hit;
  logic [15:0]       w_off;
  logic [RAM_AW-1:0] w_idx;
  logic              w_wr_led;
  logic              w_wr_timer;
  logic              w_wr_txdata;
  logic              w_wr_txstat;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic [2:0]        w_count;
  logic [7:0]        w_head;
  logic              w_unused;

  assign w_ram_hit  = (data_sram_addr[31:RAM_AW+2] == RAM_BASE[31:RAM_AW+2]);
  assign w_mmio_hit = (data_sram_addr[31:16] == MMIO_BASE[31:16]) && !w_ram_hit;
  assign w_off      = {data_sram_addr[15:2], 2'b00};
  assign w_idx      = data_sram_addr[RAM_AW+1:2];
  assign w_unused   = ^data_sram_addr[1:0];

  assign w_wr_led    = data_sram_we && w_mmio_hit && (w_off == OFF_LED);
  assign w_wr_timer  = data_sram_we && w_mmio_hit && (w_off == OFF_TIMER);
  assign w_wr_txdata = data_sram_we && w_mmio_hit && (w_off == OFF_TXDATA);
  assign w_wr_txstat = data_sram_we && w_mmio_hit && (w_off == OFF_TXSTAT);
  assign w_pop       = !w_empty && tx_ready;

  assign led      = r_led;
  assign tx_valid = !w_empty;
  assign tx_data  = w_head;

  tx_fifo4 u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_wr_txdata),
    .i_data  (data_sram_wdata[7:0]),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_head  (w_head)
  );

  // RAM write port; contents survive reset but a write during reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && data_sram_we && w_ram_hit) begin
      r_mem[w_idx] <= data_sram_wdata;
    end
  end

  // MMIO registers, switch synchroniser and the overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_led     <= 16'h0000;
      r_sw_meta <= 8'h00;
      r_sw_sync <= 8'h00;
      r_timer   <= 32'h0000_0000;
      r_ovf     <= 1'b0;
    end else begin
      if (w_wr_led) begin
        r_led <= data_sram_wdata[15:0];
      end
      r_sw_meta <= switch;
      r_sw_sync <= r_sw_meta;
      if (w_wr_timer) begin
        r_timer <= data_sram_wdata;
      end else begin
        r_timer <= r_timer + 32'd1;
      end
      // Clear and a dropped push are mutually exclusive on the single port.
      if (w_wr_txstat && data_sram_wdata[TXSTAT_OVF]) begin
        r_ovf <= 1'b0;
      end else if (w_wr_txdata && w_full) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Read mux, combinational from the address.
  always_comb begin
    data_sram_rdata = 32'h0000_0000;
    if (w_ram_hit) begin
      data_sram_rdata = r_mem[w_idx];
    end else if (w_mmio_hit) begin
      case (w_off)
        OFF_LED:    data_sram_rdata = {16'h0000, r_led};
        OFF_SWITCH: data_sram_rdata = {24'h00_0000, r_sw_sync};
        OFF_TIMER:  data_sram_rdata = r_timer;
        OFF_TXSTAT: data_sram_rdata = txstat_pack(w_count, r_ovf, w_full, w_empty);
        default:    data_sram_rdata = 32'h0000_0000;
      endcase
    end else begin
      data_sram_rdata = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_dsram_responder.sv
// Directed bench for dsram_responder: RAM, timer, switch/LED, TX FIFO and
// unmapped-address behaviour, each scenario checking hand-computed values.
module tb_dsram_responder;

  localparam logic [31:0] A_LED    = 32'hBFAF_F000;
  localparam logic [31:0] A_SWITCH = 32'hBFAF_F004;
  localparam logic [31:0] A_TIMER  = 32'hBFAF_F008;
  localparam logic [31:0] A_TXDATA = 32'hBFAF_F010;
  localparam logic [31:0] A_TXSTAT = 32'hBFAF_F014;

  logic        clk;
  logic        reset;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  switch_in;
  logic [15:0] led;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  int total;
  int bad;

  dsram_responder dut (
    .clk             (clk),
    .reset           (reset),
    .data_sram_we    (we),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .switch          (switch_in),
    .led             (led),
    .tx_valid        (tx_valid),
    .tx_data         (tx_data),
    .tx_ready        (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    step();
    we = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    we = 1'b0; addr = a;
    #1;
    d = rdata;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset = 1'b1; tx_ready = 1'b0; switch_in = 8'h00;
    we = 1'b1; addr = A_LED; wdata = 32'hFFFF_FFFF;
    step();
    step();
    reset = 1'b0; we = 1'b0;
    total++; if (led !== 16'h0000) begin bad++; $display("FAIL reset_led got=%h exp=%h", led, 16'h0000); end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
    bus_read(A_TIMER, rd);
    total++; if (rd !== 32'h0000_0000) begin bad++; $display("FAIL reset_timer got=%h exp=%h", rd, 32'h0); end
    bus_read(A_TXSTAT, rd);
    total++; if (rd !== 32'h0000_0001) begin bad++; $display("FAIL reset_txstat got=%h exp=%h", rd, 32'h1); end
  endtask

  task automatic test_ram();
    logic [31:0] rd;
    step();
    bus_write(32'h1C00_0010, 32'hDEAD_BEEF);
    we = 1'b1; addr = 32'h1C00_0010; wdata = 32'h1234_5678;
    #1;
    rd = rdata;
    total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_rdw_old got=%h exp=%h", rd, 32'hDEAD_BEEF); end
    step();
    we = 1'b0;
    bus_read(32'h1C00_0010, rd);
    total++; if (rd !== 32'h1234_5678) begin bad++; $display("FAIL ram_new got=%h exp=%h", rd, 32'h1234_5678); end
    bus_read(32'h1C00_0013, rd);
    total++; if (rd !== 32'h1234_5678) begin bad++; $display("FAIL ram_lowbits got=%h exp=%h", rd, 32'h1234_5678); end
    step();
    bus_write(32'h1C00_03FC, 32'hA5A5_0001);
    bus_read(32'h1C00_03FC, rd);
    total++; if (rd !== 32'hA5A5_0001) begin bad++; $display("FAIL ram_top got=%h exp=%h", rd, 32'hA5A5_0001); end
    bus_read(32'h1C00_0400, rd);
    total++; if (rd !== 32'h0000_0000) begin bad++; $display("FAIL ram_outside got=%h exp=%h", rd, 32'h0); end
    bus_read(32'h1C00_0010, rd);
    total++; if (rd !== 32'h1234_5678) begin bad++; $display("FAIL ram_keep got=%h exp=%h", rd, 32'h1234_5678); end
  endtask

  task automatic test_timer();
    logic [31:0] rd;
    step();
    bus_write(A_TIMER, 32'hFFFF_FFFE);
    bus_read(A_TIMER, rd);
    total++; if (rd !== 32'hFFFF_FFFE) begin bad++; $display("FAIL timer_load got=%h exp=%h", rd, 32'hFFFF_FFFE); end
    step();
    bus_read(A_TIMER, rd);
    total++; if (rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL timer_1 got=%h exp=%h", rd, 32'hFFFF_FFFF); end
    step();
    bus_read(A_TIMER, rd);
    total++; if (rd !== 32'h0000_0000) begin bad++; $display("FAIL timer_wrap got=%h exp=%h", rd, 32'h0); end
    step();
    bus_read(A_TIMER, rd);
    total++; if (rd !== 32'h0000_0001) begin bad++; $display("FAIL timer_3 got=%h exp=%h", rd, 32'h1); end
  endtask

  task automatic test_switch_led();
    logic [31:0] rd;
    step();
    switch_in = 8'hA5;
    bus_read(A_SWITCH, rd);
    total++; if (rd !== 32'h0000_0000) begin bad++; $display("FAIL sw_cycle0 got=%h exp=%h", rd, 32'h0); end
    step();
    bus_read(A_SWITCH, rd);
    total++; if (rd !== 32'h0000_0000) begin bad++; $display("FAIL sw_cycle1 got=%h exp=%h", rd, 32'h0); end
    step();
    bus_read(A_SWITCH, rd);
    total++; if (rd !== 32'h0000_00A5) begin bad++; $display("FAIL sw_cycle2 got=%h exp=%h", rd, 32'hA5); end
    step();
    bus_write(A_LED, 32'hABCD_1234);
    total++; if (led !== 16'h1234) begin bad++; $display("FAIL led_port got=%h exp=%h", led, 16'h1234); end
    bus_read(A_LED, rd);
    total++; if (rd !== 32'h0000_1234) begin bad++; $display("FAIL led_read got=%h exp=%h", rd, 32'h1234); end
  endtask

  task automatic test_tx_overflow();
    logic [31:0] rd;
    logic [7:0]  exp_b;
    step();
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_b = 8'h41 + 8'(i);
      bus_write(A_TXDATA, {24'h0, exp_b});
    end
    bus_read(A_TXSTAT, rd);
    total++; if (rd !== 32'h0000_0046) begin bad++; $display("FAIL ovf_txstat got=%h exp=%h", rd, 32'h46); end
    total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL ovf_valid got=%b exp=1", tx_valid); end
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_b = 8'h41 + 8'(i);
      total++; if (tx_data !== exp_b) begin bad++; $display("FAIL drain_byte%0d got=%h exp=%h", i, tx_data, exp_b); end
      step();
    end
    tx_ready = 1'b0;
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL drain_empty_valid got=%b exp=0", tx_valid); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL drain_empty_data got=%h exp=00", tx_data); end
    bus_read(A_TXSTAT, rd);
    total++; if (rd !== 32'h0000_0005) begin bad++; $display("FAIL drain_txstat got=%h exp=%h", rd, 32'h5); end
    step();
    bus_write(A_TXSTAT, 32'h0000_0004);
    bus_read(A_TXSTAT, rd);
    total++; if (rd !== 32'h0000_0001) begin bad++; $display("FAIL ovf_clear got=%h exp=%h", rd, 32'h1); end
    bus_read(A_TXDATA, rd);
    total++; if (rd !== 32'h0000_0000) begin bad++; $display("FAIL txdata_read got=%h exp=%h", rd, 32'h0); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] rd;
    logic [7:0]  exp_q [3];
    step();
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_write(A_TXDATA, 32'h0000_0061 + 32'(i));
    end
    tx_ready = 1'b1; we = 1'b1; addr = A_TXDATA; wdata = 32'h0000_0055;
    step();
    we = 1'b0; tx_ready = 1'b0;
    bus_read(A_TXSTAT, rd);
    total++; if (rd !== 32'h0000_0034) begin bad++; $display("FAIL fullpp_txstat got=%h exp=%h", rd, 32'h34); end
    total++; if (tx_data !== 8'h62) begin bad++; $display("FAIL fullpp_head got=%h exp=62", tx_data); end
    step();
    bus_write(A_TXSTAT, 32'h0000_0004);
    bus_read(A_TXSTAT, rd);
    total++; if (rd !== 32'h0000_0030) begin bad++; $display("FAIL fullpp_clear got=%h exp=%h", rd, 32'h30); end
    step();
    tx_ready = 1'b1; we = 1'b1; addr = A_TXDATA; wdata = 32'h0000_0066;
    step();
    we = 1'b0; tx_ready = 1'b0;
    bus_read(A_TXSTAT, rd);
    total++; if (rd !== 32'h0000_0030) begin bad++; $display("FAIL pushpop_count got=%h exp=%h", rd, 32'h30); end
    total++; if (tx_data !== 8'h63) begin bad++; $display("FAIL pushpop_head got=%h exp=63", tx_data); end
    exp_q[0] = 8'h63; exp_q[1] = 8'h64; exp_q[2] = 8'h66;
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++; if (tx_data !== exp_q[i]) begin bad++; $display("FAIL order_byte%0d got=%h exp=%h", i, tx_data, exp_q[i]); end
      step();
    end
    tx_ready = 1'b0;
    bus_read(A_TXSTAT, rd);
    total++; if (rd !== 32'h0000_0001) begin bad++; $display("FAIL order_empty got=%h exp=%h", rd, 32'h1); end
  endtask

  task automatic test_unmapped();
    logic [31:0] rd;
    step();
    bus_read(32'h0000_0000, rd);
    total++; if (rd !== 32'h0000_0000) begin bad++; $display("FAIL unmapped_zero got=%h exp=%h", rd, 32'h0); end
    bus_read(32'hBFAF_F020, rd);
    total++; if (rd !== 32'h0000_0000) begin bad++; $display("FAIL unmapped_f020 got=%h exp=%h", rd, 32'h0); end
    bus_read(32'hBFAF_F00C, rd);
    total++; if (rd !== 32'h0000_0000) begin bad++; $display("FAIL unmapped_f00c got=%h exp=%h", rd, 32'h0); end
    step();
    bus_write(32'h0000_0000, 32'hFFFF_FFFF);
    bus_write(32'hBFAF_F020, 32'hFFFF_FFFF);
    bus_write(A_SWITCH, 32'h0000_0000);
    total++; if (led !== 16'h1234) begin bad++; $display("FAIL unmapped_led got=%h exp=%h", led, 16'h1234); end
    bus_read(A_TXSTAT, rd);
    total++; if (rd !== 32'h0000_0001) begin bad++; $display("FAIL unmapped_txstat got=%h exp=%h", rd, 32'h1); end
    bus_read(A_SWITCH, rd);
    total++; if (rd !== 32'h0000_00A5) begin bad++; $display("FAIL switch_ro got=%h exp=%h", rd, 32'hA5); end
    bus_read(32'h1C00_0010, rd);
    total++; if (rd !== 32'h1234_5678) begin bad++; $display("FAIL unmapped_ram got=%h exp=%h", rd, 32'h1234_5678); end
  endtask

  task automatic test_push_empty();
    step();
    we = 1'b1; addr = A_TXDATA; wdata = 32'h0000_0077;
    #1;
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL push_empty_bypass got=%b exp=0", tx_valid); end
    step();
    we = 1'b0;
    total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL push_empty_valid got=%b exp=1", tx_valid); end
    total++; if (tx_data !== 8'h77) begin bad++; $display("FAIL push_empty_data got=%h exp=77", tx_data); end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] rd;
    bus_write(A_TXDATA, 32'h0000_0078);
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL midreset_valid got=%b exp=0", tx_valid); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL midreset_data got=%h exp=00", tx_data); end
    total++; if (led !== 16'h0000) begin bad++; $display("FAIL midreset_led got=%h exp=%h", led, 16'h0000); end
    bus_read(A_TXSTAT, rd);
    total++; if (rd !== 32'h0000_0001) begin bad++; $display("FAIL midreset_txstat got=%h exp=%h", rd, 32'h1); end
    bus_read(32'h1C00_0010, rd);
    total++; if (rd !== 32'h1234_5678) begin bad++; $display("FAIL midreset_ram got=%h exp=%h", rd, 32'h1234_5678); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    we = 1'b0;
    addr = 32'h0000_0000;
    wdata = 32'h0000_0000;
    switch_in = 8'h00;
    tx_ready = 1'b0;
    test_reset();
    test_ram();
    test_timer();
    test_switch_led();
    test_tx_overflow();
    test_full_push_pop();
    test_unmapped();
    test_push_empty();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dsram_responder.md
DSRAM_RESPONDER -- requirements
Module: dsram_responder

Interface
REQ-001 Parameter RAM_BASE, default 32'h1C00_0000, byte base address of the internal data RAM window.
REQ-002 Parameter RAM_AW, default 8, RAM word-address width (2^RAM_AW 32-bit words).
REQ-003 Parameter MMIO_BASE, default 32'hBFAF_0000, base of the 64 KB MMIO window.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 data_sram_we  input  1  write strobe from CPU data port, word write.
REQ-007 data_sram_addr  input  32  byte address from CPU; bits [1:0] ignored.
REQ-008 data_sram_wdata  input  32  write data.
REQ-009 data_sram_rdata  output  32  read data, combinational from data_sram_addr.
REQ-010 switch  input  8  asynchronous board switches.
REQ-011 led  output  16  LED register value.
REQ-012 tx_valid  output  1  TX FIFO head valid.
REQ-013 tx_data  output  8  TX FIFO head byte.
REQ-014 tx_ready  input  1  downstream accepts head byte this cycle.

Function
REQ-015 Decode: RAM hit when addr[31:RAM_AW+2] equals RAM_BASE[31:RAM_AW+2]; MMIO hit when addr[31:16] equals MMIO_BASE[31:16]; else unmapped.
REQ-016 RAM read: rdata = mem[addr[RAM_AW+1:2]] in the same cycle (zero-latency, CPU consumes it combinationally); write stored at clk edge when we high.
REQ-017 Read-during-write to same RAM word returns the old value in that cycle; new value visible next cycle.
REQ-018 MMIO offset 0xF000 LED: RW, bits [15:0]; read returns {16'b0, led}.
REQ-019 MMIO offset 0xF004 SWITCH: RO, two-flop synchronised switch, read returns {24'b0, sw_sync}; writes ignored.
REQ-020 MMIO offset 0xF008 TIMER: 32-bit counter, +1 every cycle, wraps 0xFFFF_FFFF -> 0; write loads wdata, load wins over increment; read returns current register value.
REQ-021 MMIO offset 0xF010 TXDATA: WO; write pushes wdata[7:0] into 4-entry FIFO if not full; read returns 0.
REQ-022 MMIO offset 0xF014 TXSTAT: read returns {25'b0, count[2:0], 1'b0, ovf, full, empty} (count in bits [6:4]); write with wdata[2]=1 clears ovf.
REQ-023 Push while full (evaluated pre-edge) is dropped and sets ovf sticky, even if a pop occurs the same cycle.
REQ-024 Pop when tx_valid && tx_ready; tx_valid = !empty; tx_data = head byte, 0 when empty.
REQ-025 Simultaneous push and pop with 1-3 entries: count unchanged, order preserved.
REQ-026 Push into empty FIFO: tx_valid rises next cycle (no same-cycle bypass).
REQ-027 Push and ovf-set in the same cycle as ovf-clear write cannot occur (single port); ovf set by a dropped push has priority only over nothing.
REQ-028 Unmapped or unlisted MMIO offsets: read returns 32'h0, writes ignored.
REQ-029 FIFO pointers 2-bit wrap-around; count 0..4.

Reset
REQ-030 On reset: led=0, sw_sync=0, timer=0, FIFO flushed (count 0, pointers 0), ovf=0, tx_valid=0, tx_data=0.
REQ-031 RAM contents are not reset.
REQ-032 Reset mid-transfer discards all FIFO entries; a write coincident with reset is ignored for all registers.

Structure
REQ-033 Shared package holds MMIO offsets (LED, SWITCH, TIMER, TXDATA, TXSTAT), TXSTAT bit positions and default bases.
REQ-034 FIFO implemented as sub-module tx_fifo4 (push/pop/full/empty/count/head); rest in dsram_responder.

Verification
REQ-035 Reset, write 0x1234_5678 to 0x1C00_0010, read 0x1C00_0010 next cycle -> 0x1234_5678; same-cycle read returns old value.
REQ-036 Write 0xFFFF_FFFE to TIMER, idle 3 cycles -> reads 0xFFFF_FFFF, then 0x0, then 0x1.
REQ-037 tx_ready=0, write 0x41,0x42,0x43,0x44,0x45 to TXDATA -> TXSTAT reads count 4, full 1, ovf 1; raise tx_ready -> bytes 0x41..0x44 out in order, then empty=1.
REQ-038 FIFO full with tx_ready=1, push 0x55 same cycle as pop -> push dropped, ovf=1, count 3; write TXSTAT 0x4 -> ovf=0.
REQ-039 switch=0xA5 -> SWITCH reads 0x0000_00A5 by third cycle, not earlier than second; LED write 0xABCD_1234 -> led=0x1234.
REQ-040 Read 0x0000_0000 and MMIO offset 0xF020 -> 0x0; write there leaves all state unchanged; reset with 2 FIFO entries -> tx_valid=0 next cycle.
